// File: rtl/uart_pkt_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkt_pkg: shared constants and enums for the UART packet controller.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkt_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_LEN    = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHK    = 3'd4,
        ST_COMMIT = 3'd5
    } pkt_state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        BAD_LEN = 2'd1,
        BAD_CHK = 2'd2,
        TIMEOUT = 2'd3
    } pkt_err_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_cmd_ctrl: frames UART bytes into SYNC/ADDR/LEN/DATA/CHK packets and
// commits checksum-verified payloads as a burst of register writes.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_cmd_ctrl
    import uart_pkt_pkg::*;
#(
    parameter int MAX_LEN        = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       pkt_done,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int            GW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam int            IW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LEN_MAX  = 8'(MAX_LEN);

    pkt_state_t    r_state, w_state_n;
    pkt_err_t      r_code, w_code_n;
    logic [7:0]    r_base, w_base_n;
    logic [7:0]    r_len, w_len_n;
    logic [7:0]    r_idx, w_idx_n;
    logic [7:0]    r_chk, w_chk_n;
    logic [GW-1:0] r_gap, w_gap_n;
    logic          r_wr_en, w_wr_en_n;
    logic [7:0]    r_wr_addr, w_wr_addr_n;
    logic [7:0]    r_wr_data, w_wr_data_n;
    logic          r_done, w_done_n;
    logic          r_err, w_err_n;
    logic          r_busy;
    logic          w_buf_we;
    logic          w_in_pkt;
    logic [IW-1:0] w_idx_lo;
    logic [7:0]    r_buf [MAX_LEN];

    assign w_in_pkt = r_state inside {ST_ADDR, ST_LEN, ST_DATA, ST_CHK};
    assign w_idx_lo = r_idx[IW-1:0];

    always_comb begin
        w_state_n   = r_state;
        w_code_n    = r_code;
        w_base_n    = r_base;
        w_len_n     = r_len;
        w_idx_n     = r_idx;
        w_chk_n     = r_chk;
        w_gap_n     = '0;
        w_wr_en_n   = 1'b0;
        w_wr_addr_n = r_wr_addr;
        w_wr_data_n = r_wr_data;
        w_done_n    = 1'b0;
        w_err_n     = 1'b0;
        w_buf_we    = 1'b0;

        if (w_in_pkt && !rx_valid) begin
            w_gap_n = r_gap + 1'b1;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (rx_valid && rx_byte == SYNC_BYTE) begin
                    w_state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (rx_valid) begin
                    w_base_n  = rx_byte;
                    w_chk_n   = rx_byte;
                    w_state_n = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_byte == 8'd0 || rx_byte > LEN_MAX) begin
                        w_err_n   = 1'b1;
                        w_code_n  = BAD_LEN;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_len_n   = rx_byte;
                        w_idx_n   = 8'd0;
                        w_chk_n   = r_chk ^ rx_byte;
                        w_state_n = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    w_buf_we = 1'b1;
                    w_chk_n  = r_chk ^ rx_byte;
                    w_idx_n  = r_idx + 8'd1;
                    if (w_idx_n == r_len) begin
                        w_state_n = ST_CHK;
                    end
                end
            end
            ST_CHK: begin
                if (rx_valid) begin
                    if (rx_byte != r_chk) begin
                        w_err_n   = 1'b1;
                        w_code_n  = BAD_CHK;
                        w_state_n = ST_IDLE;
                    end else begin
                        // First write leaves on the edge that accepts CHK.
                        w_wr_en_n   = 1'b1;
                        w_wr_addr_n = r_base;
                        w_wr_data_n = r_buf[0];
                        w_idx_n     = 8'd1;
                        w_state_n   = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                if (r_idx == r_len) begin
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end else begin
                    w_wr_en_n   = 1'b1;
                    w_wr_addr_n = r_base + r_idx;
                    w_wr_data_n = r_buf[w_idx_lo];
                    w_idx_n     = r_idx + 8'd1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase

        // A byte on the expiry cycle takes priority over the timeout.
        if (w_in_pkt && !rx_valid && r_gap == GAP_LAST) begin
            w_err_n   = 1'b1;
            w_code_n  = TIMEOUT;
            w_state_n = ST_IDLE;
            w_gap_n   = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_code    <= NONE;
            r_base    <= 8'd0;
            r_len     <= 8'd0;
            r_idx     <= 8'd0;
            r_chk     <= 8'd0;
            r_gap     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 8'd0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_code    <= w_code_n;
            r_base    <= w_base_n;
            r_len     <= w_len_n;
            r_idx     <= w_idx_n;
            r_chk     <= w_chk_n;
            r_gap     <= w_gap_n;
            r_wr_en   <= w_wr_en_n;
            r_wr_addr <= w_wr_addr_n;
            r_wr_data <= w_wr_data_n;
            r_done    <= w_done_n;
            r_err     <= w_err_n;
            r_busy    <= (w_state_n != ST_IDLE);
        end
    end

    always_ff @(posedge CLK) begin
        if (w_buf_we) begin
            r_buf[w_idx_lo] <= rx_byte;
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign pkt_done = r_done;
    assign pkt_err  = r_err;
    assign err_code = r_code;
    assign busy     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_cmd_ctrl: directed packets against a queue-based packet model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx_cmd_ctrl;

    localparam int MAXL = 16;
    localparam int TO   = 50;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       wr_en, pkt_done, pkt_err, busy;
    logic [7:0] wr_addr, wr_data;
    logic [1:0] err_code;

    uart_rx_cmd_ctrl #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packet-level model: collects bytes after SYNC, decides the packet's
    // fate once enough bytes are in, and replays queued writes.
    bit          m_valid = 1'b0;
    bit          in_pkt;
    bit          done_due;
    int          idle;
    logic [7:0]  q[$];
    logic [15:0] pend[$];
    logic [7:0]  x;
    logic        e_wr_en, e_done, e_err, e_busy;
    logic [7:0]  e_addr, e_data;
    logic [1:0]  e_code;

    task pop_write();
        {e_addr, e_data} = pend.pop_front();
        e_wr_en = 1'b1;
        if (pend.size() == 0) done_due = 1'b1;
    endtask

    task fail_pkt(input logic [1:0] c);
        e_err  = 1'b1;
        e_code = c;
        in_pkt = 1'b0;
    endtask

    always @(posedge CLK) begin
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (RST) begin
            m_valid = 1'b1; in_pkt = 1'b0; done_due = 1'b0; idle = 0;
            q.delete(); pend.delete();
            e_addr = 8'h00; e_data = 8'h00; e_code = 2'd0;
        end else if (done_due) begin
            e_done = 1'b1; done_due = 1'b0;
        end else if (pend.size() > 0) begin
            pop_write();
        end else if (!in_pkt) begin
            if (rx_valid && rx_byte == 8'hA5) begin
                in_pkt = 1'b1; q.delete(); idle = 0;
            end
        end else if (rx_valid) begin
            idle = 0;
            q.push_back(rx_byte);
            if (q.size() == 2 && (q[1] == 8'd0 || int'(q[1]) > MAXL)) begin
                fail_pkt(2'd1);
            end else if (q.size() >= 2 && q.size() == int'(q[1]) + 3) begin
                x = 8'h00;
                for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
                if (x != q[q.size()-1]) begin
                    fail_pkt(2'd2);
                end else begin
                    for (int i = 0; i < int'(q[1]); i++) pend.push_back({q[0] + 8'(i), q[2+i]});
                    in_pkt = 1'b0;
                    pop_write();
                end
            end
        end else begin
            idle++;
            if (idle == TO) fail_pkt(2'd3);
        end
        e_busy = in_pkt || (pend.size() > 0) || done_due;
    end

    logic [15:0] wlog[$];
    int          n_done = 0;
    int          n_err  = 0;

    always @(negedge CLK) begin
        if (m_valid) begin
            check("wr_en", wr_en, e_wr_en);
            check("wr_addr", wr_addr, e_addr);
            check("wr_data", wr_data, e_data);
            check("pkt_done", pkt_done, e_done);
            check("pkt_err", pkt_err, e_err);
            check("err_code", err_code, e_code);
            check("busy", busy, e_busy);
        end
        if (!RST) begin
            if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
            if (pkt_done === 1'b1) n_done++;
            if (pkt_err === 1'b1) n_err++;
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Bytes are taken MSB-first from v; called on a falling edge, returns on one.
    task automatic send_bytes(input logic [63:0] v, input int n);
        for (int k = 0; k < n; k++) begin
            rx_valid = 1'b1;
            rx_byte  = v[8*(n-1-k) +: 8];
            @(negedge CLK);
        end
        rx_valid = 1'b0;
    endtask

    task automatic clr();
        wlog.delete();
        n_done = 0;
        n_err  = 0;
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        check("reset_outputs", {wr_en, wr_addr, wr_data, pkt_done, pkt_err, err_code, busy}, 32'h0);

        // Good packet
        clr();
        send_bytes(64'hA5_10_02_11_22_21, 6);
        check("good_w0", {wr_en, wr_addr, wr_data}, {1'b1, 8'h10, 8'h11});
        idle_cycles(1);
        check("good_w1", {wr_en, wr_addr, wr_data}, {1'b1, 8'h11, 8'h22});
        idle_cycles(1);
        check("good_done", {wr_en, pkt_done, busy}, 3'b010);
        idle_cycles(2);
        check("good_counts", {wlog.size(), n_done, n_err}, {32'd2, 32'd1, 32'd0});

        // Bad checksum
        clr();
        send_bytes(64'hA5_10_02_11_22_20, 6);
        check("badchk_err", {pkt_err, err_code, busy}, {1'b1, 2'd2, 1'b0});
        idle_cycles(3);
        check("badchk_nowr", wlog.size(), 0);

        // Bad length: zero and above MAX_LEN
        clr();
        send_bytes(64'hA5_10_00, 3);
        check("len0_err", {pkt_err, err_code}, {1'b1, 2'd1});
        idle_cycles(2);
        send_bytes(64'hA5_10_11, 3);
        check("len17_err", {pkt_err, err_code}, {1'b1, 2'd1});
        idle_cycles(2);
        check("badlen_counts", {wlog.size(), n_err}, {32'd0, 32'd2});

        // Address wrap
        clr();
        send_bytes(64'hA5_FF_02_AA_BB_EC, 6);
        idle_cycles(4);
        check("wrap_n", wlog.size(), 2);
        if (wlog.size() == 2) begin
            check("wrap_w0", wlog[0], 16'hFFAA);
            check("wrap_w1", wlog[1], 16'h00BB);
        end

        // Timeout after the address byte
        clr();
        send_bytes(64'hA5_10, 2);
        idle_cycles(TO - 1);
        check("to_before", {pkt_err, busy}, 2'b01);
        idle_cycles(1);
        check("to_err", {pkt_err, err_code, busy}, {1'b1, 2'd3, 1'b0});
        idle_cycles(2);

        // Byte on the expiry cycle wins
        clr();
        send_bytes(64'hA5_10, 2);
        idle_cycles(TO - 1);
        send_bytes(64'h02_11_22_21, 4);
        idle_cycles(4);
        check("expiry_counts", {wlog.size(), n_done, n_err}, {32'd2, 32'd1, 32'd0});

        // Reset in the middle of DATA
        clr();
        send_bytes(64'hA5_10_02_11, 4);
        RST = 1'b1;
        @(negedge CLK);
        check("rst_mid", {wr_en, wr_addr, wr_data, pkt_done, pkt_err, err_code, busy}, 32'h0);
        RST = 1'b0;
        idle_cycles(5);
        check("rst_mid_quiet", {wlog.size(), n_err, n_done}, {32'd0, 32'd0, 32'd0});

        // Leading junk then a good packet
        clr();
        send_bytes(64'h00_FF_A5_20_01_5A_7B, 7);
        idle_cycles(4);
        check("junk_counts", {wlog.size(), n_done, n_err}, {32'd1, 32'd1, 32'd0});
        if (wlog.size() == 1) check("junk_w0", wlog[0], 16'h205A);

        idle_cycles(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_cmd_ctrl.md
# uart_rx_cmd_ctrl

Packet-level controller that sits directly behind the UART receiver and consumes its byte stream. It frames bytes as `SYNC, ADDR, LEN, DATA[LEN], CHK` and buffers the payload. After the checksum verifies, it commits the payload as a burst of byte writes to the register bus. Malformed, corrupted or stalled packets are discarded and reported with an error code; nothing is written.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum payload bytes per packet. Legal range 1..255.
- `TIMEOUT_CYCLES`, default 100000: maximum idle clock cycles allowed between bytes inside a packet.

Ports:
- `CLK` — in — 1 — clock. All logic is on the rising edge.
- `RST` — in — 1 — reset; synchronous, active-high.
- `rx_valid` — in — 1 — single-cycle strobe; `rx_byte` is valid on this cycle.
- `rx_byte` — in — 8 — received byte.
- `wr_en` — out — 1 — register write strobe, one cycle per byte.
- `wr_addr` — out — 8 — write address.
- `wr_data` — out — 8 — write data.
- `pkt_done` — out — 1 — one-cycle pulse after the last write of a good packet.
- `pkt_err` — out — 1 — one-cycle pulse when a packet is discarded.
- `err_code` — out — 2 — error cause. Valid while `pkt_err` is high; held until the next error.
- `busy` — out — 1 — high whenever the state is not IDLE.

## Operation
- Packet format: `SYNC` = 0xA5, `ADDR`, `LEN`, `LEN` data bytes, then `CHK`.
- `CHK` = XOR of `ADDR`, `LEN` and all data bytes. `SYNC` is excluded.
- States: IDLE, ADDR, LEN, DATA, CHK, COMMIT.
- IDLE:
  - `rx_byte` = 0xA5 → ADDR.
  - Any other byte is dropped silently, with no error.
- ADDR: latch the start address and seed the running checksum with it → LEN.
- LEN:
  - `LEN` = 0 or `LEN` > `MAX_LEN` → error code 1, then IDLE.
  - Otherwise latch `LEN`, clear the byte index → DATA.
- DATA:
  - Store each byte at `buf[idx]` and XOR it into the checksum.
  - After byte number `LEN` → CHK.
- CHK:
  - Received byte ≠ running checksum → error code 2, then IDLE.
  - Match → COMMIT.
- COMMIT:
  - Emit `LEN` consecutive writes: `wr_addr` = (`ADDR` + i) mod 256, `wr_data` = `buf[i]`, for i = 0..`LEN`-1.
  - Then pulse `pkt_done` → IDLE.
- Inter-byte timeout:
  - The gap counter runs in ADDR, LEN, DATA and CHK.
  - It clears on every accepted byte.
  - Reaching `TIMEOUT_CYCLES` → error code 3, then IDLE.
- Error code 0 is reserved and means "no error since reset".
- `rx_valid` in COMMIT is ignored and the byte is dropped. COMMIT lasts at most `MAX_LEN` cycles, far shorter than one UART byte time.
- The payload buffer is never cleared. Stale contents are unreachable because writes are bounded by `LEN`.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pkt_done`=0, `pkt_err`=0, `err_code`=0, `busy`=0. State = IDLE; counters and checksum = 0.
- Reset mid-packet: the partial packet is abandoned with no `pkt_err` and no writes.
- All outputs are registered.
- Error pulse timing:
  - `pkt_err` is high on the cycle after the offending `LEN` or `CHK` byte's `rx_valid`.
  - For a timeout, `pkt_err` is high on the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Write timing:
  - The first `wr_en` is high on the cycle after the `CHK` byte's `rx_valid`.
  - `wr_en` stays high for exactly `LEN` consecutive cycles.
  - `pkt_done` is high on the cycle after the last `wr_en`.
- Simultaneous byte and timeout: `rx_valid` on the expiry cycle wins. The byte is accepted and the counter clears.
- `busy` rises on the cycle after `SYNC` is accepted. It falls on the same cycle `pkt_done` or `pkt_err` is high.
- Widths:
  - Address arithmetic is 8-bit and wraps.
  - Byte index and length registers are 8-bit.
  - Timeout counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Structure
- Package `uart_pkt_pkg` holds:
  - `SYNC_BYTE` = 8'hA5.
  - The state enum `pkt_state_t`.
  - The error enum `pkt_err_t`: NONE=0, BAD_LEN=1, BAD_CHK=2, TIMEOUT=3.
- Single module. The payload buffer is an inline `MAX_LEN`×8 register array; no sub-module is needed.

## Test plan
- Good packet: bytes A5 10 02 11 22 21 → writes (0x10,0x11) then (0x11,0x22) on consecutive cycles; `pkt_done` pulses once; no `pkt_err`.
- Bad checksum: bytes A5 10 02 11 22 20 → `pkt_err`, `err_code`=2, zero `wr_en` cycles, `busy` low afterwards.
- Bad length:
  - Bytes A5 10 00 → `err_code`=1 on the cycle after the `LEN` byte.
  - With `MAX_LEN`=16, `LEN`=0x11 → `err_code`=1.
- Address wrap: bytes A5 FF 02 AA BB EC → writes (0xFF,0xAA) then (0x00,0xBB).
- Timeout (`TIMEOUT_CYCLES`=50):
  - Bytes A5 10, then silence → `pkt_err` with `err_code`=3 at 50 cycles after the last byte.
  - A byte arriving exactly on the expiry cycle is accepted instead.
- Reset and junk:
  - Assert `RST` during DATA → all outputs at reset values, no write.
  - Leading junk bytes 00 FF are ignored, and the following good packet commits normally.
